i2s_frame_serializer: RTL and testbench
=======================================

// Module: i2s_frame_serializer
// PURPOSE
// Consumes stereo samples from the mixer through a valid/ready handshake and serializes them as I2S to the DAC.
// - Runs entirely on the DAC system clock using internal clock enables; there are no derived clocks.
// - Drives the DAC sclk, lrclk and sd pins.
// - Double-buffers samples so the upstream side may deliver at any time within a frame.
// PARAMETERS
// WIDTH      24  sample width, two's complement, WIDTH <= SLOT_BITS
// SLOT_BITS  24  sclk periods per channel slot
// SCLK_DIV    8  clk cycles per sclk period; must be even and >= 2
// PORTS
// clk          in   1          DAC system clock (384 x Fs)
// rst          in   1          synchronous reset, active-high
// enable       in   1          serializer run; low = serializer idle
// in_left      in   WIDTH      left sample, signed
// in_right     in   WIDTH      right sample, signed
// in_valid     in   1          sample pair valid
// in_ready     out  1          holding buffer can accept a pair
// sclk         out  1          I2S bit clock, registered
// lrclk        out  1          I2S word select (0 = left), registered
// sd           out  1          I2S serial data, registered
// frame_tick   out  1          1-cycle pulse when a frame is latched into the shifter
// underrun_cnt out  16         saturating count of frames latched with an empty holding buffer
// BEHAVIOUR
// Reset (rst=1 at a clk edge):
// - div_cnt, bit_cnt, holding, full and the 2*SLOT_BITS shifter all clear to 0.
// - Outputs sclk, lrclk, sd, frame_tick and underrun_cnt are 0. in_ready is 0 while rst=1.
// - Reset mid-frame aborts the frame immediately; the next frame restarts at bit_cnt=0.
// Dividers:
// - div_cnt counts 0..SCLK_DIV-1 and wraps.
// - sclk = 1 when div_cnt >= SCLK_DIV/2, else 0.
// - Fall event: div_cnt wraps SCLK_DIV-1 -> 0. bit_cnt advances 0..2*SLOT_BITS-1 and wraps on each fall event.
// - lrclk = (bit_cnt >= SLOT_BITS).
// - sd changes only on fall events, so it is stable across each sclk rise.
// Frame word:
// - F = {in_left, pad, in_right, pad}, each channel MSB-aligned in its slot with zero LSB padding.
// Latch:
// - Occurs on the fall event where bit_cnt goes 0 -> 1.
// - If full=1, the shifter loads F from the holding buffer and full clears.
// - If full=0, the shifter reloads the previous frame and underrun_cnt increments, saturating at 0xFFFF.
// - frame_tick pulses in the cycle after every latch.
// - Latch and shift happen on the same fall event, so the frame MSB appears on sd there.
// - On each later fall event sd shifts to the next bit of F.
// - F bit 0 (the right-slot LSB) is driven during bit_cnt=0 of the following frame. This is the standard I2S one-bit delay.
// - After reset, sd = 0 until the first latch.
// Handshake:
// - Transfer occurs when in_valid && in_ready at a clk edge: sets full and captures in_left/in_right.
// - in_ready = !full || latch_this_cycle, gated off during rst.
// - Transfer in the latch cycle is legal: the old pair goes to the shifter and the new pair to holding, with no loss.
// - in_valid=1 while in_ready=0 is held off; upstream keeps its data stable.
// Latency:
// - Accepted pair -> MSB on sd at the next latch, at most SCLK_DIV*2*SLOT_BITS clk cycles (384 at defaults).
// enable=0:
// - div_cnt, bit_cnt and the shifter clear; sclk, lrclk, sd and frame_tick are 0; underrun_cnt holds.
// - The holding buffer and handshake keep working.
// - Re-enable starts cleanly at bit_cnt=0. The first latch uses holding if full, else the cleared shifter and it counts as an underrun.
// Rate at defaults:
// - clk 18.432 MHz gives sclk 2.304 MHz, lrclk 48 kHz, and frame_tick every 384 clk cycles.
// TESTING
// 1. Release rst with enable=1 -> sclk period 8 clk (4 low, 4 high), lrclk period 384, first frame_tick 8 clk after release.
// 2. Send L=0xA5A5A5, R=0x5A5A5A before the first latch, sample sd on sclk rise -> left bits 1..24 = 0xA5A5A5, right = 0x5A5A5A, next-frame bit 0 = LSB of R (0).
// 3. Send L=0x800000, R=0x7FFFFF, then no more input -> identical frame repeats, underrun_cnt = 1, 2, 3 on successive frame_ticks.
// 4. Hold in_valid=1 with changing data -> exactly one accept per frame, aligned with the latch cycle; no pair dropped or duplicated (scoreboard order).
// 5. Drop enable mid-left-slot at bit_cnt=10 -> next cycle sclk=lrclk=sd=0; on re-enable, the pending pair is sent intact from bit 1.
// 6. Assert rst at bit_cnt=30 with full=1 -> all outputs 0, in_ready=0 during rst, pending pair discarded, underrun_cnt=0.

Source files
------------

// File: rtl/i2s_frame_serializer.sv
// I2S transmitter: double-buffered stereo sample intake, serialized on sclk/lrclk/sd
// generated from the system clock through clock enables only.
module i2s_frame_serializer #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned SLOT_BITS = 24,
    parameter int unsigned SCLK_DIV  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd,
    output logic             frame_tick,
    output logic [15:0]      underrun_cnt
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned DIV_W      = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LIM = BIT_W'(SLOT_BITS);
    localparam logic [15:0]      UND_MAX  = 16'hFFFF;

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shifter;
    logic [WIDTH-1:0]      hold_l;
    logic [WIDTH-1:0]      hold_r;
    logic                  full;

    logic                  fall_c;
    logic                  latch_c;
    logic                  accept_c;
    logic [DIV_W-1:0]      div_nxt_c;
    logic [BIT_W-1:0]      bit_nxt_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic [FRAME_BITS-1:0] src_c;

    // Divider chain: fall event at div_cnt wrap, latch on the fall where bit_cnt leaves 0.
    always_comb begin
        fall_c    = enable && (div_cnt == DIV_LAST);
        latch_c   = fall_c && (bit_cnt == '0);
        div_nxt_c = '0;
        bit_nxt_c = '0;
        if (enable) begin
            div_nxt_c = fall_c ? '0 : div_cnt + DIV_W'(1);
            bit_nxt_c = bit_cnt;
            if (fall_c) begin
                bit_nxt_c = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

    // Frame word: each channel MSB-aligned in its slot, zero LSB padding.
    always_comb begin
        frame_c = '0;
        frame_c[FRAME_BITS-1 -: WIDTH] = hold_l;
        frame_c[SLOT_BITS-1 -: WIDTH]  = hold_r;
    end

    // The shifter rotates, so after a full frame it holds that frame again; an
    // underrun latch therefore replays the previous frame with no extra storage.
    always_comb begin
        src_c = (latch_c && full) ? frame_c : shifter;
    end

    assign in_ready = !rst && (!full || latch_c);
    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shifter      <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            full         <= 1'b0;
            sclk         <= 1'b0;
            lrclk        <= 1'b0;
            sd           <= 1'b0;
            frame_tick   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            div_cnt    <= div_nxt_c;
            bit_cnt    <= bit_nxt_c;
            sclk       <= (div_nxt_c >= DIV_HALF);
            lrclk      <= (bit_nxt_c >= SLOT_LIM);
            frame_tick <= latch_c;

            if (!enable) begin
                shifter <= '0;
                sd      <= 1'b0;
            end else if (fall_c) begin
                sd      <= src_c[FRAME_BITS-1];
                shifter <= {src_c[FRAME_BITS-2:0], src_c[FRAME_BITS-1]};
            end

            if (latch_c && !full && (underrun_cnt != UND_MAX)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end

            // A transfer in the latch cycle refills holding after its old pair moved out.
            if (accept_c) begin
                full   <= 1'b1;
                hold_l <= in_left;
                hold_r <= in_right;
            end else if (latch_c) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Bench for i2s_frame_serializer: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_i2s_frame_serializer;

    localparam int unsigned W         = 24;
    localparam int unsigned S         = 24;
    localparam int unsigned D         = 8;
    localparam int unsigned FB        = 2 * S;
    localparam int unsigned FRAME_CYC = D * FB;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [W-1:0] in_left;
    logic [W-1:0] in_right;
    logic         in_valid;
    logic         in_ready;
    logic         sclk;
    logic         lrclk;
    logic         sd;
    logic         frame_tick;
    logic [15:0]  underrun_cnt;

    i2s_frame_serializer #(.WIDTH(W), .SLOT_BITS(S), .SCLK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sd           (sd),
        .frame_tick   (frame_tick),
        .underrun_cnt (underrun_cnt)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: elapsed running cycles, current frame, holding queue, underruns.
    int unsigned   m_n = 0;
    logic [FB-1:0] m_frame = '0;
    logic [FB-1:0] m_q[$];
    logic [15:0]   m_und = '0;
    logic          m_tick = 1'b0;

    logic          dut_acc = 1'b0;
    int            cyc = 0;
    int            tick_cnt = 0;
    int            tick_cyc[16];
    logic          cap_on = 1'b0;
    int            cap_cnt = 0;
    logic [63:0]   cap_word = '0;
    logic          prev_sclk = 1'b0;

    function automatic logic [FB-1:0] mkf(input logic [W-1:0] l, input logic [W-1:0] r);
        logic [FB-1:0] f;
        f = '0;
        f[FB-1 -: W] = l;
        f[S-1 -: W]  = r;
        return f;
    endfunction

    function automatic int unsigned m_bit();
        return (m_n / D) % FB;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check registered outputs.
    task automatic step(input logic r, input logic en, input logic v,
                        input logic [W-1:0] l, input logic [W-1:0] rr);
        logic        latch;
        logic        rdy;
        int unsigned b;
        logic        sd_e;
        rst = r; enable = en; in_valid = v; in_left = l; in_right = rr;
        #1;
        latch = !r && en && ((m_n % FRAME_CYC) == D - 1);
        rdy   = !r && ((m_q.size() == 0) || latch);
        check("in_ready", 64'(in_ready), 64'(rdy));
        dut_acc = in_valid && in_ready;
        if (r) begin
            m_n = 0; m_frame = '0; m_q.delete(); m_und = '0; m_tick = 1'b0;
        end else begin
            m_tick = latch;
            if (latch) begin
                if (m_q.size() > 0) m_frame = m_q.pop_front();
                else if (m_und != 16'hFFFF) m_und++;
            end
            if (v && rdy) m_q.push_back(mkf(l, rr));
            if (en) m_n++;
            else begin m_n = 0; m_frame = '0; end
        end
        @(negedge clk);
        cyc++;
        b    = m_bit();
        sd_e = (b == 0) ? m_frame[0] : m_frame[FB - b];
        check("sclk", 64'(sclk), 64'((m_n % D) >= D / 2));
        check("lrclk", 64'(lrclk), 64'(b >= S));
        check("sd", 64'(sd), 64'(sd_e));
        check("frame_tick", 64'(frame_tick), 64'(m_tick));
        check("underrun_cnt", 64'(underrun_cnt), 64'(m_und));
        if (frame_tick) begin
            if (tick_cnt < 16) tick_cyc[tick_cnt] = cyc;
            tick_cnt++;
        end
        if (cap_on && sclk && !prev_sclk) begin
            cap_word = {cap_word[62:0], sd};
            cap_cnt++;
        end
        prev_sclk = sclk;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, '0);
        cyc = 0;
        tick_cnt = 0;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int guard = 0;
        do begin
            step(1'b0, 1'b1, 1'b1, l, r);
            guard++;
        end while (!dut_acc && guard < 2 * FRAME_CYC);
        if (!dut_acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_until_ticks(input int target);
        int guard = 0;
        while (tick_cnt < target && guard < 4 * FRAME_CYC) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
        end
        if (tick_cnt < target) check("tick_timeout", 64'(tick_cnt), 64'(target));
    endtask

    task automatic run_until_bit(input int unsigned target);
        int guard = 0;
        while (m_bit() != target && guard < 2 * FRAME_CYC) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
        end
        if (m_bit() != target) check("bit_timeout", 64'(m_bit()), 64'(target));
    endtask

    // Collect sd on n successive sclk rises.
    task automatic capture(input int n);
        int guard = 0;
        cap_on = 1'b1; cap_cnt = 0; cap_word = '0;
        while (cap_cnt < n && guard < 2 * FRAME_CYC) begin
            step(1'b0, 1'b1, 1'b0, '0, '0);
            guard++;
        end
        cap_on = 1'b0;
        if (cap_cnt < n) check("capture_timeout", 64'(cap_cnt), 64'(n));
    endtask

    initial begin : main
        int            acc_cnt;
        logic [W-1:0]  pl, pr;
        logic          pv, en_r, rr;
        int            prob, dis;

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
        @(negedge clk);

        // Reset state, first-frame timing and the A5/5A frame on the wire.
        do_reset(3);
        check("reset_underrun", 64'(underrun_cnt), 64'(0));
        check("reset_sclk", 64'(sclk), 64'(0));
        send(24'hA5A5A5, 24'h5A5A5A);
        run_until_ticks(1);
        check("first_tick_cycle", 64'(tick_cyc[0]), 64'(8));
        capture(48);
        check("frame_left", 64'(cap_word[47:24]), 64'(24'hA5A5A5));
        check("frame_right", 64'(cap_word[23:0]), 64'(24'h5A5A5A));
        check("next_bit0", 64'(cap_word[0]), 64'(0));
        run_until_ticks(2);
        check("tick_interval", 64'(tick_cyc[1] - tick_cyc[0]), 64'(384));

        // Single pair then starvation: frame repeats, underruns count 1,2,3.
        do_reset(2);
        send(24'h800000, 24'h7FFFFF);
        run_until_ticks(1);
        check("und_after_load", 64'(underrun_cnt), 64'(0));
        capture(48);
        check("extreme_frame", 64'(cap_word[47:0]), 64'(48'h800000_7FFFFF));
        run_until_ticks(2);
        check("und_1", 64'(underrun_cnt), 64'(1));
        capture(48);
        check("repeat_frame", 64'(cap_word[47:0]), 64'(48'h800000_7FFFFF));
        run_until_ticks(3);
        check("und_2", 64'(underrun_cnt), 64'(2));
        run_until_ticks(4);
        check("und_3", 64'(underrun_cnt), 64'(3));

        // in_valid held high with changing data: one accept per latch.
        do_reset(2);
        acc_cnt = 0;
        pl = W'($urandom); pr = W'($urandom);
        for (int g = 0; g < 6 * FRAME_CYC && tick_cnt < 5; g++) begin
            step(1'b0, 1'b1, 1'b1, pl, pr);
            if (dut_acc) begin
                acc_cnt++;
                pl = W'($urandom); pr = W'($urandom);
            end
        end
        check("held_valid_accepts", 64'(acc_cnt), 64'(6));

        // Enable dropped mid-left-slot with a pending pair.
        do_reset(2);
        send(24'h0F0F0F, 24'hF0F0F0);
        run_until_ticks(1);
        send(24'h123456, 24'hFEDCBA);
        run_until_bit(10);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("dis_sclk", 64'(sclk), 64'(0));
        check("dis_lrclk", 64'(lrclk), 64'(0));
        check("dis_sd", 64'(sd), 64'(0));
        for (int i = 0; i < 37; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
        tick_cnt = 0;
        run_until_ticks(1);
        check("reen_underrun", 64'(underrun_cnt), 64'(0));
        capture(48);
        check("reen_frame", 64'(cap_word[47:0]), 64'(48'h123456_FEDCBA));

        // Reset mid-frame with a full holding buffer discards the pending pair.
        do_reset(2);
        send(24'h111111, 24'h222222);
        run_until_ticks(1);
        send(24'h333333, 24'h444444);
        run_until_bit(30);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 24'h555555, 24'h666666);
            check("rst_in_ready", 64'(in_ready), 64'(0));
        end
        cyc = 0; tick_cnt = 0;
        check("rst_underrun", 64'(underrun_cnt), 64'(0));
        run_until_ticks(1);
        check("rst_discard_und", 64'(underrun_cnt), 64'(1));
        capture(48);
        check("rst_discard_frame", 64'(cap_word[47:0]), 64'(0));

        // Randomized traffic, enable gaps and occasional resets.
        pv = 1'b0; en_r = 1'b1; dis = 0; prob = 50; pl = '0; pr = '0;
        for (int c = 0; c < 30000; c++) begin
            if (c % 1000 == 0) prob = int'($urandom_range(0, 100));
            rr = ($urandom_range(0, 4999) == 0);
            if (en_r && $urandom_range(0, 1499) == 0) begin
                en_r = 1'b0;
                dis  = int'($urandom_range(1, 200));
            end else if (!en_r) begin
                if (dis == 0) en_r = 1'b1;
                else dis--;
            end
            if (!pv && int'($urandom_range(0, 99)) < prob) begin
                pv = 1'b1; pl = W'($urandom); pr = W'($urandom);
            end
            step(rr, en_r, pv, pl, pr);
            if (dut_acc) pv = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
